// File: rtl/jump_key_conditioner_if.sv
// Handshake bundle between the raw jump key pin and the game-logic request outputs.
interface jump_key_conditioner_if;
   logic       key_i;
   logic       jmp_o;
   logic       key_level_o;
   logic [7:0] press_cnt_o;

   modport master (output key_i, input jmp_o, key_level_o, press_cnt_o);
   modport slave  (input key_i, output jmp_o, key_level_o, press_cnt_o);
endinterface

// File: rtl/jump_key_conditioner.sv
// Synchronises, debounces and auto-repeats the jump push-button into single-cycle
// jump requests for the game logic.
module jump_key_conditioner #(
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned DEBOUNCE       = 2400,
   parameter int unsigned REPEAT         = 36000,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   jump_key_conditioner_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
   localparam bit               REP_EN   = (REPEAT != 0);
   // Guarded by REP_EN, so the REPEAT=0 underflow value is never compared.
   localparam logic [CNT_W-1:0] REP_LAST = REP_EN ? CNT_W'(REPEAT - 1) : '0;

   state_t           state;
   logic             s1;
   logic             s2;
   logic             k;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rep;
   logic             jmp;
   logic             level;
   logic [7:0]       press_cnt;

   assign k               = s2 ^ KEY_ACTIVE_LOW;
   assign bus.jmp_o       = jmp;
   assign bus.key_level_o = level;
   assign bus.press_cnt_o = press_cnt;

   // Synchroniser, debounce FSM and pulse counter; every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1        <= KEY_ACTIVE_LOW;
         s2        <= KEY_ACTIVE_LOW;
         state     <= IDLE;
         cnt       <= '0;
         rep       <= '0;
         jmp       <= 1'b0;
         level     <= 1'b0;
         press_cnt <= 8'd0;
      end else begin
         s1  <= bus.key_i;
         s2  <= s1;
         jmp <= 1'b0;
         unique case (state)
            IDLE: begin
               if (k) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!k) begin
                  state <= IDLE;
               end else if (cnt == DB_LAST) begin
                  state     <= HELD;
                  jmp       <= 1'b1;
                  level     <= 1'b1;
                  rep       <= '0;
                  press_cnt <= press_cnt + 8'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (!k) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end else if (REP_EN && (rep == REP_LAST)) begin
                  jmp       <= 1'b1;
                  rep       <= '0;
                  press_cnt <= press_cnt + 8'd1;
               end else begin
                  rep <= rep + CNT_W'(1);
               end
            end
            RELEASE_WAIT: begin
               // A re-press here is release bounce: resume HELD silently, repeat phase kept.
               if (k) begin
                  state <= HELD;
               end else if (cnt == DB_LAST) begin
                  state <= IDLE;
                  level <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jump_key_conditioner.sv
// Bench for jump_key_conditioner: one instance with repeat (REPEAT=10), one without,
// both fed the same pin and checked every cycle against a run-length model.
module tb_jump_key_conditioner;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pin = 1'b1;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   jump_key_conditioner_if bus_a ();
   jump_key_conditioner_if bus_b ();

   assign bus_a.key_i = pin;
   assign bus_b.key_i = pin;

   jump_key_conditioner #(.CNT_W(16), .DEBOUNCE(D), .REPEAT(10), .KEY_ACTIVE_LOW(1'b1))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   jump_key_conditioner #(.CNT_W(16), .DEBOUNCE(D), .REPEAT(0), .KEY_ACTIVE_LOW(1'b1))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;

   // Model state: logical key pipeline, run lengths of the debounced-side key,
   // and a count of held cycles since the last pulse.
   bit m_p1[2], m_p2[2], m_prevk[2], m_level[2], m_jmp[2];
   int m_run1[2], m_run0[2], m_rep[2], m_pcnt[2];

   function automatic int rep_of(input int i);
      return (i == 0) ? 10 : 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_prevk[i] = 1'b0;
         m_level[i] = 1'b0; m_jmp[i] = 1'b0;
         m_run1[i] = 0; m_run0[i] = 0; m_rep[i] = 0; m_pcnt[i] = 0;
      end
   endtask

   task automatic pulse(input int i);
      m_jmp[i]  = 1'b1;
      m_pcnt[i] = (m_pcnt[i] + 1) % 256;
      m_rep[i]  = 0;
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit k;
         k = m_p2[i];
         m_p2[i] = m_p1[i];
         m_p1[i] = !pin;
         m_jmp[i] = 1'b0;
         if (k) begin m_run1[i]++; m_run0[i] = 0; end
         else   begin m_run0[i]++; m_run1[i] = 0; end
         if (!m_level[i]) begin
            if (m_run1[i] >= D + 1) begin
               m_level[i] = 1'b1;
               pulse(i);
            end
         end else if (!k) begin
            if (m_run0[i] >= D + 1) m_level[i] = 1'b0;
         end else if (m_prevk[i]) begin
            // Only uninterrupted held cycles advance the repeat phase.
            m_rep[i]++;
            if (rep_of(i) != 0 && m_rep[i] == rep_of(i)) pulse(i);
         end
         m_prevk[i] = k;
      end
   endtask

   always @(posedge rst) model_reset();
   always @(posedge clk) if (!rst) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         chk("jmp_a",   64'(bus_a.jmp_o),       64'(m_jmp[0]));
         chk("level_a", 64'(bus_a.key_level_o), 64'(m_level[0]));
         chk("pcnt_a",  64'(bus_a.press_cnt_o), 64'(m_pcnt[0]));
         chk("jmp_b",   64'(bus_b.jmp_o),       64'(m_jmp[1]));
         chk("level_b", 64'(bus_b.key_level_o), 64'(m_level[1]));
         chk("pcnt_b",  64'(bus_b.press_cnt_o), 64'(m_pcnt[1]));
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      pin = 1'b1;
      #2 rst = 1'b1;
      tick(3);
      rst = 1'b0;
   endtask

   // Bit e of pvec = key pressed at edge e; returns jmp/level seen after each edge.
   task automatic run_pattern(input logic [63:0] pvec, input int n,
                              output logic [63:0] ja, output logic [63:0] jb,
                              output logic [63:0] la);
      logic [63:0] v;
      v = pvec;
      ja = '0; jb = '0; la = '0;
      for (int e = 0; e < n; e++) begin
         pin = !v[e];
         tick(1);
         ja[e] = bus_a.jmp_o;
         jb[e] = bus_b.jmp_o;
         la[e] = bus_a.key_level_o;
      end
   endtask

   initial begin
      logic [63:0] ja, jb, la, one;
      int na, nb;
      one = 64'd1;
      model_reset();
      #1 rst = 1'b1;
      #2;
      chk("reset_jmp",   64'(bus_a.jmp_o), 64'd0);
      chk("reset_level", 64'(bus_a.key_level_o), 64'd0);
      chk("reset_pcnt",  64'(bus_a.press_cnt_o), 64'd0);
      tick(2);
      rst = 1'b0;
      chk_en = 1'b1;

      // Clean press held 30 cycles.
      run_pattern((one << 30) - 1, 30, ja, jb, la);
      chk("clean_jmp_a", ja, (one << 6) | (one << 16) | (one << 26));
      chk("clean_jmp_b", jb, one << 6);
      chk("clean_level", la, ((one << 30) - 1) & ~((one << 6) - 1));
      chk("clean_pcnt_a", 64'(bus_a.press_cnt_o), 64'd3);
      chk("clean_model_pcnt", 64'(m_pcnt[0]), 64'd3);
      pin = 1'b1;
      tick(10);
      chk("clean_release", 64'(bus_a.key_level_o), 64'd0);

      // Bounce on press: 3 low, 2 high, then held.
      apply_reset();
      run_pattern(((one << 20) - 1) & ~(64'd3 << 3), 20, ja, jb, la);
      chk("bounce_press_a", ja, one << 11);
      chk("bounce_press_b", jb, one << 11);
      pin = 1'b1;
      tick(10);

      // Bounce on release: hold 8, then two 2-cycle re-presses.
      apply_reset();
      run_pattern(64'hFF | (64'd3 << 10) | (64'd3 << 14), 30, ja, jb, la);
      chk("bounce_rel_jmp", ja, one << 6);
      chk("bounce_rel_level", la, ((one << 22) - 1) & ~((one << 6) - 1));
      chk("bounce_rel_pcnt", 64'(bus_a.press_cnt_o), 64'd1);

      // Long hold: repeat on A, single pulse on B.
      apply_reset();
      pin = 1'b0;
      na = 0; nb = 0;
      for (int e = 0; e < 100; e++) begin
         tick(1);
         na += int'(bus_a.jmp_o);
         nb += int'(bus_b.jmp_o);
      end
      chk("hold_pulses_a", 64'(na), 64'd10);
      chk("hold_pulses_b", 64'(nb), 64'd1);
      chk("hold_pcnt_b", 64'(bus_b.press_cnt_o), 64'd1);
      pin = 1'b1;
      tick(10);

      // Counter wrap after 256 presses.
      apply_reset();
      for (int p = 0; p < 256; p++) begin
         pin = 1'b0; tick(8);
         pin = 1'b1; tick(8);
      end
      chk("wrap_pcnt_a", 64'(bus_a.press_cnt_o), 64'd0);
      chk("wrap_pcnt_b", 64'(bus_b.press_cnt_o), 64'd0);
      pin = 1'b0; tick(8);
      pin = 1'b1; tick(8);
      chk("wrap_257_a", 64'(bus_a.press_cnt_o), 64'd1);

      // Reset during PRESS_WAIT.
      apply_reset();
      pin = 1'b0; tick(8);
      pin = 1'b1; tick(8);
      pin = 1'b0; tick(4);
      #2 rst = 1'b1;
      #1;
      chk("rst_pw_pcnt",  64'(bus_a.press_cnt_o), 64'd1 - 64'd1);
      chk("rst_pw_level", 64'(bus_a.key_level_o), 64'd0);
      tick(2);
      rst = 1'b0;

      // Key still held after reset: full qualification, then reset in the jmp cycle.
      run_pattern((one << 7) - 1, 7, ja, jb, la);
      chk("rst_requal", ja, one << 6);
      chk("rst_jmp_hi", 64'(bus_a.jmp_o), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_jmp_clear",  64'(bus_a.jmp_o), 64'd0);
      chk("rst_pcnt_clear", 64'(bus_a.press_cnt_o), 64'd0);
      chk("rst_lvl_clear",  64'(bus_a.key_level_o), 64'd0);
      tick(2);
      rst = 1'b0;
      run_pattern((one << 10) - 1, 10, ja, jb, la);
      chk("rst_requal2", ja, one << 6);
      pin = 1'b1;
      tick(10);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
